ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequencing controller that shares the single-ported 512×32 synchronous RAM between the instruction-fetch path and the data (ld/st) path of the CPU. It accepts level-held requests from both ports and arbitrates round-robin on contention. It drives the RAM's address, write-enable and data-in lines for exactly one cycle per access, then returns read data with a one-cycle acknowledge. It sits between the control unit/MAR-MDR logic and the RAM instance.

## Interface
Parameters:
- ADDR_W, 9, word-address bits actually decoded by the RAM (512 words)
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clear  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  32  fetch word address
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch port
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load; sampled with d_req
- d_addr  in  32  data word address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for data port
- mem_address  out  32  to RAM address
- mem_read  out  1  to RAM Read
- mem_write  out  1  to RAM write
- mem_datain  out  DATA_W  to RAM Mdatain
- mem_q  in  DATA_W  from RAM Q (registered in RAM, one-cycle read latency)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP. Encoding 2 bits, registered.
- IDLE: if no request, stay. If exactly one request is high, grant it. If both are high, grant the port opposite to last_grant. Latch the granted port's address, we and wdata into mem_* regs. Update last_grant. Go to ACCESS.
- Address rule: mem_address = {zeros, addr[ADDR_W-1:0]}; upper bits are discarded (wrap modulo 2^ADDR_W). Fetch is always a read; it ignores d_we.
- ACCESS: mem_write = latched we; mem_read = ~latched we. Exactly one cycle. RAM performs the write or loads Q on the closing edge. Go to CAPTURE.
- CAPTURE: mem_write=0, mem_read=0. On the closing edge, register mem_q into the granted port's rdata, and on a write register the written data. Set that port's ack. Go to RESP.
- RESP: the granted port's ack=1 for this cycle only. The other ack stays 0. Requests are ignored in RESP. Go to IDLE.
- A requester must have dropped req by the first IDLE cycle after its ack, or it is taken as a new request.
- Outside ACCESS, mem_address and mem_datain hold their last value, and mem_write=0.

## Timing
- Reset values (async on clear): state=IDLE, if_ack=d_ack=0, if_rdata=d_rdata=0, mem_address=0, mem_datain=0, mem_read=mem_write=0, busy=0, last_grant=fetch. With last_grant=fetch, data wins the first contention.
- Latency: req high at edge E0 in IDLE → ACCESS after E0 → CAPTURE after E1 → ack high in the cycle after E2. That is 3 cycles from the granting edge to the ack cycle. Back-to-back throughput is one access per 4 cycles.
- Simultaneous requests: exactly one grant per IDLE visit. The loser's req stays high and is granted at the next IDLE, so there is no starvation.
- clear asserted mid-ACCESS aborts the access: mem_write drops immediately, and no ack is issued for the aborted request.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared header ram_ctrl_defs.vh: state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_CAPTURE=2'd2, ST_RESP=2'd3; port IDs PORT_IF=1'b0, PORT_D=1'b1; ADDR_W and DATA_W defaults.
- One sub-module, rr_arb2: a 2-requester round-robin grant with a last_grant register, enabled only in IDLE. The FSM and datapath registers stay in ram_arbiter.

## Test plan
- Reset, then d_req=1, d_we=1, d_addr=0x87, d_wdata=0xDEADBEEF → mem_write=1 for exactly one cycle with mem_address=0x87; d_ack pulses 3 cycles after grant; RAM word 0x87 = 0xDEADBEEF.
- After the above, if_req=1, if_addr=0x87 → if_ack pulse with if_rdata=0xDEADBEEF; mem_write stays 0 throughout.
- if_req and d_req raised on the same edge, both held → data granted first (d_ack), then fetch (if_ack) 4 cycles later; repeat with both held again → fetch first.
- d_addr=0x0000_0295 load → mem_address=0x095 (wrapped); data returned equals memory[0x95].
- clear pulsed during ACCESS of a store → mem_write=0 asynchronously, no d_ack, state IDLE, busy=0; a subsequent request completes normally.
- Requester holds if_req one cycle past if_ack → second fetch issued; verify 4-cycle spacing and no ack in the RESP cycle.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, port IDs and
// default bus widths.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. On contention the port that did not win
// last time is granted; last_grant only moves when a grant is actually given.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic grant_valid,
    output logic grant_port
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection: single requester wins outright, contention alternates.
    always_comb begin
        grant_valid  = en & (req_if | req_d);
        grant_port   = PORT_IF;
        last_grant_d = last_grant_q;
        if (req_if && req_d) begin
            grant_port = ~last_grant_q;
        end else if (req_d) begin
            grant_port = PORT_D;
        end
        if (grant_valid) begin
            last_grant_d = grant_port;
        end
    end

    // last_grant register; fetch counts as last winner out of reset.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            last_grant_q <= PORT_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-ported synchronous RAM between the fetch and data ports.
// Each access walks IDLE -> ACCESS -> CAPTURE -> RESP; every output is a flop.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [31:0]       mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    localparam int PAD_W = 32 - ADDR_W;

    state_t            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [31:0]       mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_datain_q, mem_datain_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              busy_q, busy_d;

    logic              grant_valid;
    logic              grant_port;

    // Address bits above the RAM depth are deliberately discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    rr_arb2 u_arb (
        .clk         (clk),
        .clear       (clear),
        .en          (state_q == ST_IDLE),
        .req_if      (if_req),
        .req_d       (d_req),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Next-state and next-output logic; strobes default low, data regs hold.
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        we_d          = we_q;
        mem_address_d = mem_address_q;
        mem_datain_d  = mem_datain_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    port_d = grant_port;
                    if (grant_port == PORT_D) begin
                        we_d          = d_we;
                        mem_address_d = {{PAD_W{1'b0}}, d_addr[ADDR_W-1:0]};
                        mem_datain_d  = d_wdata;
                    end else begin
                        // Fetch is always a read, whatever d_we says.
                        we_d          = 1'b0;
                        mem_address_d = {{PAD_W{1'b0}}, if_addr[ADDR_W-1:0]};
                    end
                    mem_write_d = we_d;
                    mem_read_d  = ~we_d;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // RAM Q is valid now; a store echoes the written word.
                if (port_q == PORT_D) begin
                    d_rdata_d = we_q ? mem_datain_q : mem_q;
                    d_ack_d   = 1'b1;
                end else begin
                    if_rdata_d = mem_q;
                    if_ack_d   = 1'b1;
                end
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; clear aborts any access in flight.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= ST_IDLE;
            port_q        <= PORT_IF;
            we_q          <= 1'b0;
            mem_address_q <= '0;
            mem_datain_q  <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            we_q          <= we_d;
            mem_address_q <= mem_address_d;
            mem_datain_q  <= mem_datain_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            busy_q        <= busy_d;
        end
    end

    assign if_rdata    = if_rdata_q;
    assign if_ack      = if_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_ack       = d_ack_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_datain  = mem_datain_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model, a transaction-timeline reference model,
// a per-cycle compare thread and directed scenarios with literal checks.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_datain;
    logic [31:0] mem_q;
    logic        busy;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk         (clk),
        .clear       (clear),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_datain  (mem_datain),
        .mem_q       (mem_q),
        .busy        (busy)
    );

    // RAM: 512x32, registered Q; unwritten words read as A5000000 | index.
    logic [31:0]  ram [0:511];
    logic [511:0] wr_mask = '0;
    always @(posedge clk) begin
        if (mem_write) begin
            ram[mem_address[8:0]]     <= mem_datain;
            wr_mask[mem_address[8:0]] <= 1'b1;
        end
        if (mem_read) begin
            mem_q <= wr_mask[mem_address[8:0]] ? ram[mem_address[8:0]]
                                               : (32'hA5000000 | {23'b0, mem_address[8:0]});
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: one transaction with its granting edge number.
    int          ec = 0;
    logic [31:0] mm [int];
    bit          m_active = 1'b0;
    bit          m_last = 1'b0;
    bit          m_port = 1'b0;
    bit          m_we = 1'b0;
    int          m_g = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_addr = '0;
    int          cd;
    bit          cact;
    bit          p;

    // Results of the latest directed transaction.
    int          i_ack_ec[$];
    logic [31:0] i_ack_dat[$];
    int          d_ack_ec[$];
    logic [31:0] d_ack_dat[$];
    int          wr_cycles;
    logic [31:0] seen_addr;
    int          start_ec;
    int          abort_acks;

    function automatic logic [31:0] mread(input int a);
        return mm.exists(a) ? mm[a] : (32'hA5000000 | 32'(a));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, ec);
        end
    endtask

    task automatic sample_cycle();
        @(negedge clk);
        if (mem_write) wr_cycles++;
        if (mem_read || mem_write) seen_addr = mem_address;
        if (if_ack) begin i_ack_ec.push_back(ec); i_ack_dat.push_back(if_rdata); end
        if (d_ack)  begin d_ack_ec.push_back(ec); d_ack_dat.push_back(d_rdata); end
    endtask

    // Raise the requested ports, drop each one hold+1 edges after its first ack.
    task automatic run_txn(input bit ri, input bit rd, input bit we,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input int hold_i);
        int  drop_i;
        int  drop_d;
        bit  pend_i;
        bit  pend_d;
        int  ni;
        int  nd;
        i_ack_ec.delete(); i_ack_dat.delete();
        d_ack_ec.delete(); d_ack_dat.delete();
        wr_cycles = 0;
        seen_addr = 32'hFFFFFFFF;
        start_ec  = ec;
        if_req = ri; if_addr = ia;
        d_req = rd; d_we = we; d_addr = da; d_wdata = wd;
        pend_i = ri; pend_d = rd; drop_i = -1; drop_d = -1;
        for (int k = 0; k < 40 && (pend_i || pend_d); k++) begin
            ni = i_ack_ec.size();
            nd = d_ack_ec.size();
            sample_cycle();
            if (i_ack_ec.size() > ni && drop_i < 0) drop_i = hold_i + 1;
            if (d_ack_ec.size() > nd && drop_d < 0) drop_d = 1;
            @(posedge clk); #1;
            if (drop_i > 0) begin
                drop_i--;
                if (drop_i == 0) begin if_req = 1'b0; pend_i = 1'b0; end
            end
            if (drop_d > 0) begin
                drop_d--;
                if (drop_d == 0) begin d_req = 1'b0; pend_d = 1'b0; end
            end
        end
        if (pend_i || pend_d) begin
            chk("txn_timeout", 32'(pend_i || pend_d), 32'd0);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        repeat (8) sample_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        clear = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        fork
            // Model: advance on each edge, grant per the round-robin rule.
            forever begin
                @(posedge clk or posedge clear);
                if (clear) begin
                    m_active = 1'b0;
                    m_last   = 1'b0;
                    m_addr   = '0;
                end else begin
                    ec++;
                    if (m_active && ec == m_g + 1) begin
                        m_data = m_we ? m_wd : mread(int'(m_a));
                        if (m_we) mm[int'(m_a)] = m_wd;
                    end
                    if ((!m_active || ec >= m_g + 4) && (if_req || d_req)) begin
                        p        = (if_req && d_req) ? !m_last : d_req;
                        m_last   = p;
                        m_port   = p;
                        m_active = 1'b1;
                        m_g      = ec;
                        m_we     = p ? d_we : 1'b0;
                        m_a      = (p ? d_addr : if_addr) % 512;
                        m_wd     = d_wdata;
                        m_addr   = m_a;
                    end
                end
            end
            // Compare: every falling edge, DUT outputs against the model.
            forever begin
                @(negedge clk);
                if (clear) begin
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_if_ack", 32'(if_ack), 32'd0);
                    chk("rst_d_ack", 32'(d_ack), 32'd0);
                    chk("rst_mem_write", 32'(mem_write), 32'd0);
                    chk("rst_mem_read", 32'(mem_read), 32'd0);
                    chk("rst_mem_address", mem_address, 32'd0);
                    chk("rst_mem_datain", mem_datain, 32'd0);
                    chk("rst_if_rdata", if_rdata, 32'd0);
                    chk("rst_d_rdata", d_rdata, 32'd0);
                end else begin
                    cd   = ec - m_g;
                    cact = m_active && cd >= 0 && cd <= 2;
                    chk("busy", 32'(busy), 32'(cact));
                    chk("mem_write", 32'(mem_write), 32'(cact && cd == 0 && m_we));
                    chk("mem_read", 32'(mem_read), 32'(cact && cd == 0 && !m_we));
                    chk("if_ack", 32'(if_ack), 32'(cact && cd == 2 && !m_port));
                    chk("d_ack", 32'(d_ack), 32'(cact && cd == 2 && m_port));
                    chk("mem_address", mem_address, m_addr);
                    if (cact && cd == 0 && m_we) chk("mem_datain", mem_datain, m_wd);
                    if (cact && cd == 2 && !m_port) chk("if_rdata", if_rdata, m_data);
                    if (cact && cd == 2 && m_port) chk("d_rdata", d_rdata, m_data);
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 clear = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);

        // Store DEADBEEF to 0x87.
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h87, 32'hDEADBEEF, 0);
        chk("t1_write_cycles", 32'(wr_cycles), 32'd1);
        chk("t1_address", seen_addr, 32'h87);
        chk("t1_ack_count", 32'(d_ack_ec.size()), 32'd1);
        if (d_ack_ec.size() > 0) chk("t1_ack_latency", 32'(d_ack_ec[0] - start_ec), 32'd3);
        chk("t1_ram_word", ram[9'h87], 32'hDEADBEEF);
        $display("txn store 0x87 <= deadbeef: d_acks=%0d writes=%0d", d_ack_ec.size(), wr_cycles);

        // Fetch back 0x87 with d_we left high; fetch must not write.
        run_txn(1'b1, 1'b0, 1'b1, 32'h87, 32'h0, 32'h0, 0);
        chk("t2_ack_count", 32'(i_ack_ec.size()), 32'd1);
        if (i_ack_dat.size() > 0) chk("t2_if_rdata", i_ack_dat[0], 32'hDEADBEEF);
        chk("t2_write_cycles", 32'(wr_cycles), 32'd0);
        $display("txn fetch 0x87: if_acks=%0d", i_ack_ec.size());

        // Contention after a fetch grant: data wins, fetch follows 4 cycles later.
        run_txn(1'b1, 1'b1, 1'b0, 32'h87, 32'h87, 32'h0, 0);
        if (i_ack_ec.size() > 0 && d_ack_ec.size() > 0)
            chk("t3_d_then_if", 32'(i_ack_ec[0] - d_ack_ec[0]), 32'd4);
        else
            chk("t3_ack_counts", 32'(i_ack_ec.size() + d_ack_ec.size()), 32'd2);
        $display("txn contention 1: if_acks=%0d d_acks=%0d", i_ack_ec.size(), d_ack_ec.size());

        // Load from 0x295 wraps to word 0x95.
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0295, 32'h0, 0);
        chk("t4_wrapped_addr", seen_addr, 32'h95);
        if (d_ack_dat.size() > 0) chk("t4_d_rdata", d_ack_dat[0], 32'hA5000095);
        $display("txn load 0x295: d_acks=%0d addr=%h", d_ack_ec.size(), seen_addr);

        // Contention after a data grant: fetch wins this time.
        run_txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h87, 32'h0, 0);
        if (i_ack_ec.size() > 0 && d_ack_ec.size() > 0) begin
            chk("t5_if_then_d", 32'(d_ack_ec[0] - i_ack_ec[0]), 32'd4);
            chk("t5_if_rdata", i_ack_dat[0], 32'hA5000010);
            chk("t5_d_rdata", d_ack_dat[0], 32'hDEADBEEF);
        end else begin
            chk("t5_ack_counts", 32'(i_ack_ec.size() + d_ack_ec.size()), 32'd2);
        end
        $display("txn contention 2: if_acks=%0d d_acks=%0d", i_ack_ec.size(), d_ack_ec.size());

        // Abort a store to 0x10 with clear during ACCESS.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678;
        @(posedge clk);
        #2 clear = 1'b1;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        d_req = 1'b0;
        #4 clear = 1'b0;
        abort_acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ack) abort_acks++;
        end
        chk("abort_no_ack", 32'(abort_acks), 32'd0);
        @(posedge clk); #1;
        $display("txn aborted store 0x10: d_acks=%0d", abort_acks);

        // The aborted store must not have reached memory.
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 0);
        chk("t6_ack_count", 32'(d_ack_ec.size()), 32'd1);
        if (d_ack_dat.size() > 0) chk("t6_d_rdata", d_ack_dat[0], 32'hA5000010);
        $display("txn load 0x10 after abort: d_acks=%0d", d_ack_ec.size());

        // Fetch held one cycle past ack is taken as a second request.
        run_txn(1'b1, 1'b0, 1'b0, 32'h87, 32'h0, 32'h0, 1);
        chk("t7_ack_count", 32'(i_ack_ec.size()), 32'd2);
        if (i_ack_ec.size() == 2) begin
            chk("t7_spacing", 32'(i_ack_ec[1] - i_ack_ec[0]), 32'd4);
            chk("t7_second_data", i_ack_dat[1], 32'hDEADBEEF);
        end
        $display("txn held fetch 0x87: if_acks=%0d", i_ack_ec.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
